sid_audio_filter: RTL and testbench



---
 rtl/sid_audio_filter.sv | 78 +++++++
 tb/tb_sid_audio_filter.sv | 113 +++++++++++
 2 files changed

// File: rtl/sid_audio_filter.sv
// sid_audio_filter: 255-clock box-car decimator followed by a shift-programmable one-pole IIR low-pass
module sid_audio_filter #(
    parameter bit PRELOAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_in,
    input  logic [2:0] cutoff_shift,
    input  logic       bypass,
    output logic [7:0] sample_out,
    output logic       sample_valid,
    output logic [7:0] frame_pos
);
    typedef enum logic {FILL, RUN} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] y_q, y_d;
    logic [7:0] out_q, out_d;
    logic valid_q, valid_d;
    logic end_edge, load;
    logic [15:0] sum;
    logic [16:0] avg_w;
    logic [7:0] avg;
    logic signed [16:0] diff, step;
    logic [15:0] y_next;
    logic [8:0] rnd;
    logic [7:0] out_next;
    // window average and IIR datapath; only meaningful on the end edge
    always_comb begin
        end_edge = cnt_q == 8'd254;
        sum = acc_q + {8'h00, sample_in};
        avg_w = ({1'b0, sum} + {9'h000, sum[15:8]} + 17'd1) >> 8;
        avg = |avg_w[16:8] ? 8'hFF : avg_w[7:0];
        diff = $signed({1'b0, avg, 8'h00}) - $signed({1'b0, y_q});
        step = diff >>> cutoff_shift;
        y_next = 16'({1'b0, y_q} + step);
        rnd = {1'b0, y_next[15:8]} + {8'h00, y_next[7]};
        out_next = rnd[8] ? 8'hFF : rnd[7:0];
    end
    // window counter and accumulator; the new window starts empty after the end edge
    always_comb begin
        cnt_d = end_edge ? 8'd0 : cnt_q + 8'd1;
        acc_d = end_edge ? 16'd0 : sum;
    end
    // next state: the first completed window moves FILL to RUN
    always_comb begin
        state_d = end_edge ? RUN : state_q;
    end
    // outputs: preload on the first window, bypass keeps y tracking the raw average
    always_comb begin
        load = (state_q == FILL && PRELOAD) || (state_q == RUN && bypass);
        y_d = !end_edge ? y_q : load ? {avg, 8'h00} : y_next;
        out_d = !end_edge ? out_q : load ? avg : out_next;
        valid_d = end_edge;
    end
    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q <= 8'd0;
            acc_q <= 16'd0;
            y_q <= 16'd0;
            out_q <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            y_q <= y_d;
            out_q <= out_d;
            valid_q <= valid_d;
        end
    end
    assign sample_out = out_q;
    assign sample_valid = valid_q;
    assign frame_pos = cnt_q;
endmodule

// File: tb/tb_sid_audio_filter.sv
// tb_sid_audio_filter: scoreboard bench for the decimating IIR audio filter
module tb_sid_audio_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] sample_in = 8'h00;
    logic [2:0] cutoff_shift = 3'd0;
    logic bypass = 1'b0;
    logic [7:0] sample_out;
    logic sample_valid;
    logic [7:0] frame_pos;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int last_valid = 0;
    logic [7:0] exp_q[$];

    sid_audio_filter dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .cutoff_shift(cutoff_shift),
        .bypass(bypass),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .frame_pos(frame_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // edge counter and the edge of the most recent reset
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_cyc <= cyc + 1;
    end

    // monitor: every valid strobe pops one expected sample and checks its spacing
    always @(negedge clk) begin
        if (sample_valid) begin
            check("valid_spacing", cyc - ((rst_cyc > last_valid) ? rst_cyc : last_valid), 255);
            last_valid = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got sample_out=%0h with no expected sample", sample_out);
            end else begin
                check("sample_out", sample_out, exp_q.pop_front());
            end
        end
    end

    // one full window: a/b alternate per clock, cutoff switches from k to k2 at cnt=100
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [2:0] k,
                             input logic [2:0] k2, input logic byp, input logic [7:0] req);
        exp_q.push_back(req);
        for (int i = 0; i < 255; i++) begin
            sample_in = (i % 2 == 1) ? b : a;
            cutoff_shift = (i < 100) ? k : k2;
            bypass = byp;
            if (i == 200) check("frame_pos", frame_pos, 200);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] rise [10] = '{8'h80, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF, 8'hFF};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out", sample_out, 0);
        check("reset_valid", sample_valid, 0);
        check("reset_pos", frame_pos, 0);
        run_frame(8'h80, 8'h80, 3'd3, 3'd3, 1'b0, 8'h80);
        run_frame(8'h80, 8'h80, 3'd3, 3'd3, 1'b0, 8'h80);
        run_frame(8'h80, 8'h80, 3'd5, 3'd5, 1'b0, 8'h80);
        run_frame(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 8'h00);
        for (int n = 0; n < 10; n++) run_frame(8'hFF, 8'hFF, 3'd1, 3'd1, 1'b0, rise[n]);
        run_frame(8'h00, 8'hFF, 3'd4, 3'd4, 1'b1, 8'h7F);
        run_frame(8'hFF, 8'h00, 3'd4, 3'd4, 1'b1, 8'h80);
        run_frame(8'hFF, 8'hFF, 3'd0, 3'd0, 1'b0, 8'hFF);
        run_frame(8'h10, 8'h10, 3'd7, 3'd7, 1'b1, 8'h10);
        run_frame(8'h10, 8'h10, 3'd7, 3'd7, 1'b0, 8'h10);
        run_frame(8'h00, 8'h00, 3'd2, 3'd2, 1'b0, 8'h0C);
        run_frame(8'h00, 8'h00, 3'd7, 3'd0, 1'b0, 8'h00);
        run_frame(8'h80, 8'h80, 3'd0, 3'd7, 1'b0, 8'h01);
        for (int i = 0; i < 120; i++) begin
            sample_in = 8'h55;
            @(posedge clk);
            #1;
        end
        check("pos_before_rst", frame_pos, 120);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out", sample_out, 0);
        check("midrst_valid", sample_valid, 0);
        check("midrst_pos", frame_pos, 0);
        run_frame(8'h40, 8'h40, 3'd7, 3'd7, 1'b0, 8'h40);
        run_frame(8'h40, 8'h40, 3'd7, 3'd7, 1'b0, 8'h40);
        repeat (5) @(posedge clk);
        #1 check("pending_samples", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
